// File: rtl/tdc_pkg.sv
// Shared types for the TDC tap decoder: FSM states, fine-width helper and
// the hit_time layout for the default 8-tap-per-phase, 16-bit coarse build.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DEAD    = 2'd3
    } tdc_state_t;

    // Bits needed to index 4*length taps.
    function automatic int fine_w(input int length);
        int n;
        int w;
        n = 32'sd1;
        w = 32'sd0;
        while (n < (32'sd4 * length)) begin
            n = n * 32'sd2;
            w = w + 32'sd1;
        end
        return w;
    endfunction

    localparam int DEF_LENGTH   = 32'sd8;
    localparam int DEF_COARSE_W = 32'sd16;
    localparam int DEF_FINE_W   = fine_w(DEF_LENGTH);

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
    } hit_time_t;

endpackage

// File: rtl/tdc_hit_fifo.sv
// Hit buffer: push/full write side, valid/ready read side with a registered
// head that holds its last value once the buffer runs empty.
module tdc_hit_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [WIDTH-1:0] hit_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic [AW:0]      remain_s;
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_next_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             full_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign full      = full_s;
    assign hit_valid = valid_r;
    assign hit_data  = data_r;

    // A full buffer still takes a push when the head leaves in the same cycle.
    always_comb begin
        pop_s        = valid_r & hit_ready;
        push_ok_s    = push & (~full_s | pop_s);
        rd_next_s    = rd_ptr_r + AW'(pop_s);
        remain_s     = count_r - (AW+1)'(pop_s);
        count_next_s = remain_s + (AW+1)'(push_ok_s);
        if (count_next_s == {(AW+1){1'b0}}) begin
            data_next_s = data_r;
        end else if (remain_s == {(AW+1){1'b0}}) begin
            data_next_s = push_data;
        end else begin
            data_next_s = mem_r[rd_next_s];
        end
    end

    // Storage and pointer/head registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
            data_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {(AW+1){1'b0}});
            data_r   <= data_next_s;
        end
    end

endmodule

// File: rtl/tdc_tap_decoder.sv
// Delay-line TDC decoder: synchronises taps, detects the token edge and
// buffers {coarse, fine} hits. Optional bubble correction: TDC_DEC_BUBBLE_FIX_EN.
module tdc_tap_decoder
    import tdc_pkg::*;
#(
    parameter int LENGTH     = 8,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DEAD_CYC   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [4*LENGTH-1:0]                 taps,
    input  logic                                enable,
    output logic                                hit_valid,
    input  logic                                hit_ready,
    output logic [COARSE_W+fine_w(LENGTH)-1:0]  hit_time,
    output logic                                overflow,
    output logic [7:0]                          drop_cnt
);

    localparam int N      = 4 * LENGTH;
    localparam int FINE_W = fine_w(LENGTH);
    localparam int HW     = COARSE_W + FINE_W;

    logic [N-1:0]        t1_r;
    logic [N-1:0]        t2_r;
    logic                prev_zero_r;
    logic [COARSE_W-1:0] counter_r;
    tdc_state_t          state_r;
    tdc_state_t          state_next_s;
    logic [3:0]          dead_cnt_r;
    logic [FINE_W-1:0]   fine_r;
    logic [COARSE_W-1:0] coarse_r;
    logic                capture_s;
    logic                push_s;
    logic                full_s;
    logic                drop_s;
    logic [N-1:0]        search_s;
    logic [FINE_W-1:0]   hi_s;
    logic                overflow_r;
    logic [7:0]          drop_cnt_r;

    // Two-stage synchroniser, previous-zero history and free coarse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1_r        <= {N{1'b0}};
            t2_r        <= {N{1'b0}};
            prev_zero_r <= 1'b0;
            counter_r   <= {COARSE_W{1'b0}};
        end else begin
            t1_r        <= taps;
            t2_r        <= t1_r;
            prev_zero_r <= (t2_r == {N{1'b0}});
            counter_r   <= counter_r + COARSE_W'(1);
        end
    end

`ifdef TDC_DEC_BUBBLE_FIX_EN
    // Fill single-tap bubbles flanked by ones before the search.
    always_comb begin
        search_s = t2_r;
        for (int i = 1; i < N - 1; i++) begin
            search_s[i] = t2_r[i] | (t2_r[i-1] & t2_r[i+1]);
        end
    end
`else
    assign search_s = t2_r;
`endif

    // Highest set bit wins.
    always_comb begin
        hi_s = {FINE_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            hi_s = search_s[i] ? FINE_W'(i) : hi_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; disarming takes priority over a same-cycle edge.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                end else if ((t2_r != {N{1'b0}}) && prev_zero_r) begin
                    state_next_s = ST_CAPTURE;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                state_next_s = ST_DEAD;
            end
            ST_DEAD: begin
                if (dead_cnt_r != 4'd0) begin
                    state_next_s = ST_DEAD;
                end else if (enable) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Dead-time countdown and hit latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_cnt_r <= 4'd0;
            fine_r     <= {FINE_W{1'b0}};
            coarse_r   <= {COARSE_W{1'b0}};
        end else begin
            if (state_r == ST_CAPTURE) begin
                dead_cnt_r <= 4'(DEAD_CYC - 1);
            end else if ((state_r == ST_DEAD) && (dead_cnt_r != 4'd0)) begin
                dead_cnt_r <= dead_cnt_r - 4'd1;
            end else begin
                dead_cnt_r <= dead_cnt_r;
            end
            if (capture_s) begin
                fine_r   <= hi_s;
                coarse_r <= counter_r;
            end
        end
    end

    assign push_s = (state_r == ST_CAPTURE);
    assign drop_s = push_s & full_s & ~(hit_valid & hit_ready);

    // Sticky overflow and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

    tdc_hit_fifo #(
        .WIDTH (HW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({coarse_r, fine_r}),
        .full      (full_s),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_data  (hit_time)
    );

endmodule

// File: tb/tb_tdc_tap_decoder.sv
// Scoreboard bench for tdc_tap_decoder with default parameters; expected hits
// are queued at stimulus time and checked by a monitor on each pop.
module tb_tdc_tap_decoder;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] taps;
    logic        enable;
    logic        hit_valid;
    logic        hit_ready;
    logic [20:0] hit_time;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    hit_time_t sb[$];
    hit_time_t last_pushed;
    logic [15:0] cyc;
    logic        hold_pend = 1'b0;
    logic [20:0] held;

    tdc_tap_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .taps      (taps),
        .enable    (enable),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_time  (hit_time),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference coarse time: cycles since reset release, modulo 2^16.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 16'd0;
        else     cyc <= cyc + 16'd1;
    end

    // Monitor: compare each popped head, and head stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && hit_valid) begin
                checks++;
                if (hit_time !== held) begin
                    errors++;
                    $display("FAIL stall_stable got %h exp %h", hit_time, held);
                end
            end
            if (hit_valid && hit_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h exp none", hit_time);
                end else begin
                    hit_time_t e;
                    e = sb.pop_front();
                    if (hit_time !== e) begin
                        errors++;
                        $display("FAIL sb_data got %h exp %h", hit_time, e);
                    end
                end
            end
            hold_pend = hit_valid && !hit_ready;
            held      = hit_time;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drive a tap burst; capture latches the counter two edges after launch.
    task automatic launch(input logic [31:0] v, input int hold, input bit expect_hit,
                          input logic [4:0] f);
        hit_time_t e;
        taps = v;
        if (expect_hit) begin
            e.coarse = cyc + 16'd2;
            e.fine   = f;
            sb.push_back(e);
            last_pushed = e;
        end
        step(hold);
        taps = 32'h0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending exp 0", name, sb.size());
        end
    endtask

    initial begin
        logic [31:0] one;
        one       = 32'h1;
        rst       = 1'b1;
        taps      = 32'h0;
        enable    = 1'b0;
        hit_ready = 1'b1;
        step(3);
        chk("rst_valid", {31'd0, hit_valid}, 32'd0);
        chk("rst_time", {11'd0, hit_time}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        step(4);

        // First hit: hit_valid must appear only after the 4th edge.
        begin
            hit_time_t e;
            e.coarse = cyc + 16'd2;
            e.fine   = 5'd7;
            sb.push_back(e);
            taps = 32'h0000_00FF;
            for (int k = 1; k <= 4; k++) begin
                step(1);
                if (k == 3) taps = 32'h0;
                chk("latency", {31'd0, hit_valid}, (k == 4) ? 32'd1 : 32'd0);
            end
        end
        step(10);

        launch(32'h0000_0F7F, 3, 1'b1, 5'd11);
        step(10);
        launch(32'h0000_0005, 3, 1'b1, 5'd2);
        step(10);

        // Second burst within dead time is ignored; after 4 zero cycles it counts.
        launch(32'h0000_0003, 2, 1'b1, 5'd1);
        step(1);
        launch(32'h0000_01FF, 2, 1'b0, 5'd0);
        step(12);
        launch(32'h0000_0003, 2, 1'b1, 5'd1);
        step(4);
        launch(32'h0000_01FF, 2, 1'b1, 5'd8);
        step(12);
        wait_drain("drain_basic");

        // Coarse wrap: capture at FFFF, then a later capture after wrapping.
        while (cyc != 16'hFFFD) step(1);
        launch(32'hFFFF_FFFF, 3, 1'b1, 5'd31);
        step(10);
        launch(32'h0000_0001, 3, 1'b1, 5'd0);
        step(10);
        wait_drain("drain_wrap");

        // Six hits with consumer stalled: four kept, two dropped.
        hit_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            launch(one << (i + 1), 3, (i < 4), 5'(i + 1));
            step(10);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("drop_two", {24'd0, drop_cnt}, 32'd2);
        // Full buffer, pop coincides with push: accepted.
        launch(32'h0000_8000, 3, 1'b1, 5'd15);
        hit_ready = 1'b1;
        step(12);
        wait_drain("drain_full");
        chk("drop_keep", {24'd0, drop_cnt}, 32'd2);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("empty_valid", {31'd0, hit_valid}, 32'd0);
        chk("empty_hold", {11'd0, hit_time}, {11'd0, last_pushed});

        // Reset mid-DEAD with one entry queued.
        hit_ready = 1'b0;
        launch(32'h0000_0100, 3, 1'b0, 5'd0);
        step(1);
        chk("dead_queued", {31'd0, hit_valid}, 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        step(2);
        chk("rst2_valid", {31'd0, hit_valid}, 32'd0);
        chk("rst2_time", {11'd0, hit_time}, 32'd0);
        chk("rst2_ovf", {31'd0, overflow}, 32'd0);
        chk("rst2_drop", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        step(2);
        taps = 32'h0000_0010;
        step(3);
        taps = 32'h0;
        step(8);
        chk("idle_ignore", {31'd0, hit_valid}, 32'd0);

        hit_ready = 1'b1;
        enable    = 1'b1;
        step(3);
        launch(32'h0001_0000, 3, 1'b1, 5'd16);
        step(12);
        wait_drain("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
